// File: rtl/veer_trace_serializer.sv
// Instruction-trace consumer: compacts up to three retired slots per cycle into a
// FIFO and streams one record per cycle; groups that do not fit are dropped and counted.
module veer_trace_serializer #(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              trace_rv_i_valid_ip,
  input  logic [95:0]             trace_rv_i_insn_ip,
  input  logic [95:0]             trace_rv_i_address_ip,
  input  logic [2:0]              trace_rv_i_exception_ip,
  input  logic [4:0]              trace_rv_i_ecause_ip,
  input  logic [2:0]              trace_rv_i_interrupt_ip,
  input  logic [31:0]             trace_rv_i_tval_ip,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_insn,
  output logic [31:0]             out_addr,
  output logic                    out_exception,
  output logic                    out_interrupt,
  output logic [4:0]              out_ecause,
  output logic [31:0]             out_tval,
  output logic                    out_overflow,
  output logic [DROP_CNT_W-1:0]   drop_count,
  output logic [$clog2(DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic                  r_pending_ovf;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [31:0] r_insn   [DEPTH];
  logic [31:0] r_addr   [DEPTH];
  logic        r_exc    [DEPTH];
  logic        r_int    [DEPTH];
  logic [4:0]  r_ecause [DEPTH];
  logic [31:0] r_tval   [DEPTH];
  logic        r_ovf    [DEPTH];

  logic [1:0]          w_n;
  logic [1:0]          w_off [3];
  logic [AW-1:0]       w_idx [3];
  logic [PW-1:0]       w_level, w_free;
  logic                w_accept, w_drop, w_pop, w_valid;
  logic [AW-1:0]       w_head;
  logic [DROP_CNT_W:0] w_drop_sum;

  always_comb begin
    w_n      = {1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]}
             + {1'b0, trace_rv_i_valid_ip[2]};
    // Each valid slot lands at wr_ptr plus the number of valid slots below it.
    w_off[0] = 2'd0;
    w_off[1] = {1'b0, trace_rv_i_valid_ip[0]};
    w_off[2] = {1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]};
    for (int unsigned i = 0; i < 3; i++) begin
      w_idx[i] = r_wr_ptr[AW-1:0] + AW'(w_off[i]);
    end
    w_level    = r_wr_ptr - r_rd_ptr;
    w_free     = PW'(DEPTH) - w_level;
    w_accept   = (w_n != 2'd0) && (PW'(w_n) <= w_free);
    w_drop     = (w_n != 2'd0) && !w_accept;
    w_valid    = (w_level != '0);
    w_pop      = w_valid && out_ready;
    w_head     = r_rd_ptr[AW-1:0];
    w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pending_ovf <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr      <= r_wr_ptr + PW'(w_n);
        r_pending_ovf <= 1'b0;
      end
      if (w_drop) begin
        r_pending_ovf <= 1'b1;
        r_drop_cnt    <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (w_accept && trace_rv_i_valid_ip[i]) begin
        r_insn[w_idx[i]]   <= trace_rv_i_insn_ip[32*i +: 32];
        r_addr[w_idx[i]]   <= trace_rv_i_address_ip[32*i +: 32];
        r_exc[w_idx[i]]    <= trace_rv_i_exception_ip[i];
        r_int[w_idx[i]]    <= trace_rv_i_interrupt_ip[i];
        r_ecause[w_idx[i]] <= (trace_rv_i_exception_ip[i] | trace_rv_i_interrupt_ip[i])
                              ? trace_rv_i_ecause_ip : '0;
        r_tval[w_idx[i]]   <= (trace_rv_i_exception_ip[i] | trace_rv_i_interrupt_ip[i])
                              ? trace_rv_i_tval_ip : '0;
        r_ovf[w_idx[i]]    <= r_pending_ovf && (w_off[i] == 2'd0);
      end
    end
  end

  always_comb begin
    out_valid     = w_valid;
    out_insn      = w_valid ? r_insn[w_head]   : '0;
    out_addr      = w_valid ? r_addr[w_head]   : '0;
    out_exception = w_valid ? r_exc[w_head]    : 1'b0;
    out_interrupt = w_valid ? r_int[w_head]    : 1'b0;
    out_ecause    = w_valid ? r_ecause[w_head] : '0;
    out_tval      = w_valid ? r_tval[w_head]   : '0;
    out_overflow  = w_valid ? r_ovf[w_head]    : 1'b0;
    drop_count    = r_drop_cnt;
    fifo_level    = w_level;
  end
endmodule

// File: tb/tb_veer_trace_serializer.sv
// Scoreboard bench for veer_trace_serializer: expected records queued at issue,
// popped and compared by a monitor whenever a record is handed off.
module tb_veer_trace_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  v_ip, exc_ip, int_ip;
  logic [95:0] insn_ip, addr_ip;
  logic [4:0]  ec_ip;
  logic [31:0] tval_ip;
  logic        out_valid, out_ready;
  logic [31:0] out_insn, out_addr, out_tval;
  logic        out_exception, out_interrupt, out_overflow;
  logic [4:0]  out_ecause;
  logic [3:0]  drop_count;
  logic [3:0]  fifo_level;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        ovf;
  } rec_t;

  rec_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   exp_drop;

  veer_trace_serializer #(.DEPTH(8), .DROP_CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .trace_rv_i_valid_ip(v_ip), .trace_rv_i_insn_ip(insn_ip),
    .trace_rv_i_address_ip(addr_ip), .trace_rv_i_exception_ip(exc_ip),
    .trace_rv_i_ecause_ip(ec_ip), .trace_rv_i_interrupt_ip(int_ip),
    .trace_rv_i_tval_ip(tval_ip),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_addr(out_addr), .out_exception(out_exception), .out_interrupt(out_interrupt),
    .out_ecause(out_ecause), .out_tval(out_tval), .out_overflow(out_overflow),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Drive a group and queue the records it should produce if accepted.
  task automatic put(input logic [2:0] v, input logic [95:0] ins, input logic [95:0] adr,
                     input logic [2:0] ex, input logic [2:0] it, input logic [4:0] ec,
                     input logic [31:0] tv, input bit acc, input bit ovf_first);
    rec_t r;
    bit   first;
    v_ip = v; insn_ip = ins; addr_ip = adr; exc_ip = ex; int_ip = it;
    ec_ip = ec; tval_ip = tv;
    first = ovf_first;
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        if (v[i]) begin
          r.insn   = ins[32*i +: 32];
          r.addr   = adr[32*i +: 32];
          r.exc    = ex[i];
          r.intr   = it[i];
          r.ecause = (ex[i] | it[i]) ? ec : 5'd0;
          r.tval   = (ex[i] | it[i]) ? tv : 32'd0;
          r.ovf    = first;
          first    = 1'b0;
          q.push_back(r);
        end
      end
    end
  endtask

  task automatic send(input logic [2:0] v, input logic [95:0] ins, input logic [95:0] adr,
                      input logic [2:0] ex, input logic [2:0] it, input logic [4:0] ec,
                      input logic [31:0] tv, input bit acc, input bit ovf_first);
    put(v, ins, adr, ex, it, ec, tv, acc, ovf_first);
    @(posedge clk); #1;
    v_ip = 3'b000;
  endtask

  task automatic simple(input logic [2:0] v, input logic [31:0] base, input bit acc,
                        input bit ovf_first);
    send(v, {base + 32'd2, base + 32'd1, base}, {base + 32'h208, base + 32'h204, base + 32'h200},
         3'b000, 3'b000, 5'd9, 32'h55AA55AA, acc, ovf_first);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    out_ready = 1'b1;
    while ((fifo_level != 0 || q.size() != 0) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, {fifo_level, 28'(q.size())}, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_record: got insn %0h expected no record", out_insn);
        end else begin
          rec_t e;
          e = q.pop_front();
          chk("record", {out_insn, out_addr, out_exception, out_interrupt, out_ecause,
                         out_tval, out_overflow}, e);
        end
      end else if (!out_valid) begin
        chk("idle_zero", {out_insn, out_addr, out_exception, out_interrupt, out_ecause,
                          out_tval, out_overflow}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    v_ip = 0; insn_ip = 0; addr_ip = 0; exc_ip = 0; int_ip = 0; ec_ip = 0; tval_ip = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;

    // 1: sparse group 101 compacts into two consecutive records
    out_ready = 1'b1;
    send(3'b101, {32'h00000013, 32'hBBBBBBBB, 32'h00100093},
         {32'h00001008, 32'h00001004, 32'h00001000}, 3'b000, 3'b000, 5'd0, 32'd0, 1, 0);
    chk("latency_valid", out_valid, 1);
    chk("latency_insn", out_insn, 32'h00100093);
    drain("t1_drain");

    // 2: fill to 6, drop a group of 3, next accepted group flags overflow
    out_ready = 1'b0;
    simple(3'b111, 32'h100, 1, 0);
    simple(3'b111, 32'h110, 1, 0);
    simple(3'b111, 32'h120, 0, 0);
    chk("t2_level", fifo_level, 6);
    chk("t2_drop", drop_count, 3);
    simple(3'b011, 32'h130, 1, 1);
    chk("t2_full", fifo_level, 8);
    drain("t2_drain");

    // 3: ecause/tval only carried on exception/interrupt records
    send(3'b010, {32'h3, 32'h00200073, 32'h1}, {32'h2008, 32'h2004, 32'h2000},
         3'b010, 3'b000, 5'd2, 32'hDEADBEEF, 1, 0);
    send(3'b001, {32'h3, 32'h2, 32'h00000013}, {32'h2018, 32'h2014, 32'h2010},
         3'b000, 3'b000, 5'd7, 32'h12345678, 1, 0);
    send(3'b100, {32'h00000033, 32'h2, 32'h1}, {32'h2028, 32'h2024, 32'h2020},
         3'b000, 3'b100, 5'd11, 32'hCAFEF00D, 1, 0);
    drain("t3_drain");

    // 4: level 7 with pop: one slot fits, two slots are dropped
    out_ready = 1'b0;
    simple(3'b111, 32'h400, 1, 0);
    simple(3'b111, 32'h410, 1, 0);
    simple(3'b001, 32'h420, 1, 0);
    chk("t4_level7", fifo_level, 7);
    out_ready = 1'b1;
    put(3'b001, {32'h0, 32'h0, 32'h430}, {32'h0, 32'h0, 32'h4300}, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("t4_push_pop", fifo_level, 7);
    put(3'b011, {32'h0, 32'h441, 32'h440}, {32'h0, 32'h4404, 32'h4400}, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    v_ip = 3'b000;
    chk("t4_drop_level", fifo_level, 6);
    chk("t4_drop_cnt", drop_count, 5);
    drain("t4_drain");

    // 5: drop counter saturates
    exp_drop = 5;
    out_ready = 1'b0;
    simple(3'b111, 32'h500, 1, 1);
    simple(3'b111, 32'h510, 1, 0);
    for (int g = 0; g < 6; g++) begin
      simple(3'b111, 32'h600 + 32'(g * 16), 0, 0);
      exp_drop = (exp_drop + 3 > 15) ? 15 : exp_drop + 3;
      chk("t5_drop_cnt", drop_count, exp_drop);
    end
    chk("t5_sat", drop_count, 4'hF);
    simple(3'b011, 32'h700, 1, 1);
    drain("t5_drain");

    // 6: async reset with level 5 and overflow pending
    out_ready = 1'b0;
    simple(3'b111, 32'h800, 1, 0);
    simple(3'b111, 32'h810, 1, 0);
    simple(3'b111, 32'h820, 0, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t6_level5", fifo_level, 5);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_drop", drop_count, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    simple(3'b001, 32'h900, 1, 0);
    drain("t6_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
